nts_ip_udp_parser: RTL
======================

// Module: nts_ip_udp_parser
// PURPOSE
//  Streaming Ethernet/IPv4(/IPv6)/UDP header parser, 64-bit word per i_process beat, big-endian
//  (byte 0 = bits [63:56] of word 0). Locates the UDP header for any IPv4 IHL (5..15) and
//  validates the IP and UDP headers. Computes the NTP payload byte offset for the NTS engine.
//  Sits beside the RX buffer; results are read via the opcode-muxed o_read_data bus.
// PARAMETERS
//  ADDR_WIDTH    10     word-address width; byte offsets are ADDR_WIDTH+3 bits
//  NTP_PORT      16'd123  UDP destination port that sets o_detect_ntp
//  MAX_IHL       4'd15  largest IPv4 IHL accepted; larger values are flagged bad
// PORTS
//  i_clk                  in   1   clock
//  i_areset               in   1   asynchronous reset, active-high
//  i_clear                in   1   sync clear; starts a new frame
//  i_process              in   1   i_data holds the next frame word
//  i_last                 in   1   qualifies i_process: this is the final word
//  i_last_word_data_valid in   8   byte-valid mask of the final word (bit7 = byte 0)
//  i_data                 in  64   frame word
//  i_read_opcode          in   4   read mux select
//  o_detect_ipv4          out  1   EtherType 0x0800 and version 4
//  o_detect_ipv6          out  1   EtherType 0x86DD and version 6 (macro only)
//  o_detect_ip_bad        out  1   IP/UDP header failed a check, or frame truncated
//  o_detect_ntp           out  1   valid UDP header, dst port == NTP_PORT
//  o_done                 out  1   parsing finished (good or bad)
//  o_read_data            out 32   combinational read mux
// BEHAVIOUR
//  - Reset/clear: all registers and outputs 0; state IDLE; word counter 0.
//  - i_clear beats i_process in the same cycle; that word is discarded.
//  - Word counter increments per i_process and saturates at 2**ADDR_WIDTH-1 (no wrap).
//  - Keeps a 128-bit window {previous word, current word} for fields straddling words.
//  - FSM: IDLE -> ETH (word0) -> IP -> UDP -> DONE | ERROR; DONE/ERROR hold until i_clear.
//   ETH: word1 gives EtherType [31:16] and version/IHL [15:8].
//    IPv4 -> IP; any other EtherType -> DONE with all detect flags 0.
//   IP(v4): total_length, flags/frag_offset, protocol. Bad if IHL<5, IHL>MAX_IHL,
//    MF=1, frag_offset!=0, protocol!=17, or total_length<IHL*4+8.
//   UDP: header at byte U = 14+IHL*4 (lane 2 or 6). Latch src/dst ports and length.
//    Bad if udp_length<8 or udp_length>total_length-IHL*4.
//  - Flags are registered; each rises the cycle after the word carrying its deciding byte.
//    o_done rises with the last UDP header byte (U+7), or immediately on any bad check.
//  - ntp_offset = U+8 in bytes (ADDR_WIDTH+3 bits); it is 0 unless DONE with no bad flag.
//  - Bad check -> ERROR: o_detect_ip_bad=1, o_done=1, o_detect_ntp=0.
//  - i_last before byte U+7 is valid (per the mask) -> ERROR (truncated).
//  - i_process in DONE/ERROR: counter advances; results frozen.
//  - Read mux: 0 {0,ntp_offset}; 1 {16'b0,udp_length}; 2 {udp_src,udp_dst};
//    3 {24'b0,ihl[3:0],state[2:0],bad}; other opcodes read 0.
// CONFIGURATION
//  NTS_IP_IPV6_EN defined: EtherType 0x86DD with version 6 sets o_detect_ipv6.
//   Header is fixed 40 bytes: U=54, ntp_offset=62.
//   Bad if next_header!=17 (no extension headers) or payload_length<8.
//  Not defined: o_detect_ipv6 tied 0; 0x86DD frames -> DONE with all flags 0.
// TESTING
//  1 IPv4 IHL=5, proto 17, udp dst 123, len 56 -> after word5: done=1, ipv4=1, ntp=1, opcode0=42
//  2 IPv4 IHL=6 (4B option), udp dst 4460 -> done after word5, ntp=0, bad=0, opcode0=46, opcode2 dst=0x116C
//  3 IPv4 IHL=4 -> after word1: bad=1, done=1; opcode0=0
//  4 IPv4 frag_offset=1, then frame with protocol 6 -> each bad=1, done=1, ntp=0
//  5 i_last on word3, mask 8'hFF, IHL=5 -> bad=1, done=1 (truncated); then i_clear -> all outputs 0
//  6 IPv6 nh=17 dst 123: with NTS_IP_IPV6_EN ipv6=1, ntp=1, opcode0=62; without: ipv6=0, done=1, ntp=0

Source files
------------

// File: rtl/nts_ip_udp_parser.sv
// Streaming Ethernet/IPv4/UDP header parser that locates the UDP header and reports the NTP payload offset.
// Defining NTS_IP_IPV6_EN adds IPv6 (fixed 40-byte header, no extension headers) detection.
module nts_ip_udp_parser #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [15:0] NTP_PORT   = 16'd123,
  parameter logic [3:0]  MAX_IHL    = 4'd15
) (
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic        i_clear,
  input  logic        i_process,
  input  logic        i_last,
  input  logic [7:0]  i_last_word_data_valid,
  input  logic [63:0] i_data,
  input  logic [3:0]  i_read_opcode,
  output logic        o_detect_ipv4,
  output logic        o_detect_ipv6,
  output logic        o_detect_ip_bad,
  output logic        o_detect_ntp,
  output logic        o_done,
  output logic [31:0] o_read_data
);

  localparam int BW = ADDR_WIDTH + 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ETH   = 3'd1,
    S_IP    = 3'd2,
    S_UDP   = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q;
  logic [63:0]           prev_word_q;
  logic                  ipv4_q, ipv4_d, ipv6_q, ipv6_d;
  logic                  bad_q, bad_d, ntp_q, ntp_d, done_q, done_d;
  logic [3:0]            ihl_q, ihl_d;
  logic [BW-1:0]         udp_byte_q, udp_byte_d;
  logic [15:0]           ip_payload_q, ip_payload_d;
  logic [15:0]           udp_src_q, udp_src_d, udp_dst_q, udp_dst_d, udp_len_q, udp_len_d;
  logic [BW-1:0]         ntp_offset_q, ntp_offset_d;

  logic [127:0]          window;
  logic [47:0]           udp_hdr;
  logic [BW-1:0]         udp_last_byte;
  logic [ADDR_WIDTH-1:0] udp_last_word;
  logic [2:0]            udp_last_lane;
  logic [15:0]           hdr_len;
  logic                  fail;

  // The UDP header always starts in the previous word (lane 2 or 6) and ends in the current one.
  assign window        = {prev_word_q, i_data};
  assign udp_hdr       = window[(7'd127 - {1'b0, udp_byte_q[2:0], 3'b000}) -: 48];
  assign udp_last_byte = udp_byte_q + BW'(7);
  assign udp_last_word = udp_last_byte[BW-1:3];
  assign udp_last_lane = udp_last_byte[2:0];
  assign hdr_len       = 16'({ihl_q, 2'b00});

  // NOTE: every combinational output starts from a default so no path leaves a latch behind.
  always_comb begin
    state_d      = state_q;
    ipv4_d       = ipv4_q;
    ipv6_d       = ipv6_q;
    bad_d        = bad_q;
    ntp_d        = ntp_q;
    done_d       = done_q;
    ihl_d        = ihl_q;
    udp_byte_d   = udp_byte_q;
    ip_payload_d = ip_payload_q;
    udp_src_d    = udp_src_q;
    udp_dst_d    = udp_dst_q;
    udp_len_d    = udp_len_q;
    ntp_offset_d = ntp_offset_q;
    fail         = 1'b0;

    if (i_process) begin
      unique case (state_q)
        S_IDLE: begin
          if (i_last) fail = 1'b1;
          else        state_d = S_ETH;
        end
        S_ETH: begin
          if (i_data[31:16] == 16'h0800 && i_data[15:12] == 4'd4) begin
            ipv4_d     = 1'b1;
            ihl_d      = i_data[11:8];
            udp_byte_d = BW'(14) + BW'({i_data[11:8], 2'b00});
            if (i_data[11:8] < 4'd5 || i_data[11:8] > MAX_IHL || i_last) fail = 1'b1;
            else state_d = S_IP;
          end
`ifdef NTS_IP_IPV6_EN
          else if (i_data[31:16] == 16'h86DD && i_data[15:12] == 4'd6) begin
            ipv6_d     = 1'b1;
            udp_byte_d = BW'(54);
            if (i_last) fail = 1'b1;
            else        state_d = S_IP;
          end
`endif
          else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        S_IP: begin
          if (ipv6_q) begin
            ip_payload_d = i_data[47:32];
            fail = (i_data[31:24] != 8'd17) || (i_data[47:32] < 16'd8);
          end else begin
            ip_payload_d = i_data[63:48] - hdr_len;
            fail = i_data[29] || (i_data[28:16] != 13'd0) || (i_data[7:0] != 8'd17) ||
                   (i_data[63:48] < hdr_len + 16'd8);
          end
          if (i_last) fail = 1'b1;
          if (!fail)  state_d = S_UDP;
        end
        S_UDP: begin
          if (word_cnt_q == udp_last_word) begin
            udp_src_d = udp_hdr[47:32];
            udp_dst_d = udp_hdr[31:16];
            udp_len_d = udp_hdr[15:0];
            // A final word is only complete if the last UDP header byte is marked valid.
            if (udp_hdr[15:0] < 16'd8 || udp_hdr[15:0] > ip_payload_q ||
                (i_last && !i_last_word_data_valid[~udp_last_lane])) begin
              fail = 1'b1;
            end else begin
              state_d      = S_DONE;
              done_d       = 1'b1;
              ntp_d        = (udp_hdr[31:16] == NTP_PORT);
              ntp_offset_d = udp_byte_q + BW'(8);
            end
          end else if (i_last) begin
            fail = 1'b1;
          end
        end
        S_DONE, S_ERROR: ;
        default: state_d = S_IDLE;
      endcase
    end

    if (fail) begin
      state_d      = S_ERROR;
      bad_d        = 1'b1;
      done_d       = 1'b1;
      ntp_d        = 1'b0;
      ntp_offset_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q      <= S_IDLE;
      word_cnt_q   <= '0;
      prev_word_q  <= '0;
      ipv4_q       <= 1'b0;
      ipv6_q       <= 1'b0;
      bad_q        <= 1'b0;
      ntp_q        <= 1'b0;
      done_q       <= 1'b0;
      ihl_q        <= '0;
      udp_byte_q   <= '0;
      ip_payload_q <= '0;
      udp_src_q    <= '0;
      udp_dst_q    <= '0;
      udp_len_q    <= '0;
      ntp_offset_q <= '0;
    end else if (i_clear) begin
      state_q      <= S_IDLE;
      word_cnt_q   <= '0;
      prev_word_q  <= '0;
      ipv4_q       <= 1'b0;
      ipv6_q       <= 1'b0;
      bad_q        <= 1'b0;
      ntp_q        <= 1'b0;
      done_q       <= 1'b0;
      ihl_q        <= '0;
      udp_byte_q   <= '0;
      ip_payload_q <= '0;
      udp_src_q    <= '0;
      udp_dst_q    <= '0;
      udp_len_q    <= '0;
      ntp_offset_q <= '0;
    end else begin
      state_q      <= state_d;
      ipv4_q       <= ipv4_d;
      ipv6_q       <= ipv6_d;
      bad_q        <= bad_d;
      ntp_q        <= ntp_d;
      done_q       <= done_d;
      ihl_q        <= ihl_d;
      udp_byte_q   <= udp_byte_d;
      ip_payload_q <= ip_payload_d;
      udp_src_q    <= udp_src_d;
      udp_dst_q    <= udp_dst_d;
      udp_len_q    <= udp_len_d;
      ntp_offset_q <= ntp_offset_d;
      if (i_process) begin
        prev_word_q <= i_data;
        if (word_cnt_q != '1) word_cnt_q <= word_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  assign o_detect_ipv4   = ipv4_q;
`ifdef NTS_IP_IPV6_EN
  assign o_detect_ipv6   = ipv6_q;
`else
  assign o_detect_ipv6   = 1'b0;
`endif
  assign o_detect_ip_bad = bad_q;
  assign o_detect_ntp    = ntp_q;
  assign o_done          = done_q;

  always_comb begin
    o_read_data = '0;
    unique case (i_read_opcode)
      4'd0:    o_read_data = 32'(ntp_offset_q);
      4'd1:    o_read_data = {16'b0, udp_len_q};
      4'd2:    o_read_data = {udp_src_q, udp_dst_q};
      4'd3:    o_read_data = {24'b0, ihl_q, state_q, bad_q};
      default: o_read_data = '0;
    endcase
  end

endmodule
